acq_sequencer: RTL and testbench
================================

# acq_sequencer

Acquisition sequencer for the scope sample path. It runs in the system clock domain and takes the ADC sample strobe and data. It sequences writes into the circular waveform buffer through pre-trigger fill, trigger wait, post-trigger capture and frame hand-off. It replaces free-running buffer writes with a defined trigger point, so the display reads a stable frame starting `PRETRIG` samples before the trigger crossing.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: buffer depth is 2^DEPTH_LOG2 samples.
- `PRETRIG`, 128: samples kept before the trigger. Must satisfy 0 < PRETRIG < 2^DEPTH_LOG2.
- `AUTO_TO`, 4096: ARMED samples without a crossing before auto mode forces a trigger.

Ports:
- `CLK`  in  1  system clock (50 MHz).
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  level; 0 forces IDLE.
- `mode`  in  2  00 normal, 01 auto, 10 single, 11 treated as normal.
- `arm`  in  1  one-cycle pulse; starts a capture in single mode.
- `slope`  in  1  0 rising, 1 falling.
- `TRIG`  in  12  trigger level, unsigned ADC code.
- `sample_valid`  in  1  one-cycle strobe per ADC conversion, already synchronous to CLK.
- `sample`  in  12  ADC code, valid with `sample_valid`.
- `frame_ack`  in  1  pulse from the display reader: frame consumed.
- `wr_en`  out  1  buffer write strobe.
- `wr_addr`  out  DEPTH_LOG2  buffer write address.
- `wr_data`  out  12  buffer write data.
- `frame_ready`  out  1  a complete frame is held in the buffer.
- `start_addr`  out  DEPTH_LOG2  address of the oldest sample in the frame.
- `trig_addr`  out  DEPTH_LOG2  address of the trigger sample.
- `auto_trig`  out  1  the current/last frame was force-triggered.
- `state_o`  out  3  IDLE=0, PREFILL=1, ARMED=2, POST=3, DONE=4.

## Operation
- Reset values: state IDLE; `wr_en`, `wr_addr`, `wr_data`, `frame_ready`, `start_addr`, `trig_addr`, `auto_trig` all 0; `prev_valid` 0; all counters 0.
- Write pointer `wp` is a free-running DEPTH_LOG2-bit counter. It increments mod 2^DEPTH_LOG2 after every write and is not cleared between frames.
- Writes occur only on `sample_valid` in PREFILL, ARMED or POST. They set `wr_addr`=wp and `wr_data`=sample.
- `prev` holds the last `sample_valid` sample in any state. `prev_valid` is cleared on entering PREFILL and set on the next sample.
- Crossing is evaluated only in ARMED, and only with `prev_valid`=1:
  - Rising: prev < TRIG && sample >= TRIG.
  - Falling: prev > TRIG && sample <= TRIG.
- State transitions:
  - IDLE -> PREFILL: `run`=1 and mode!=single, or `run`=1 and `arm`=1. Clears pre/post/timeout counters, `frame_ready` and `auto_trig`.
  - PREFILL -> ARMED: on the write that makes pre_cnt reach PRETRIG.
  - ARMED -> POST: on a crossing sample. Alternatively, in auto mode, on the sample that makes to_cnt reach AUTO_TO; that sample sets `auto_trig`=1. The triggering sample is written; `trig_addr`=its address, post_cnt=1.
  - POST -> DONE: on the write that makes post_cnt reach 2^DEPTH_LOG2 - PRETRIG. Then `frame_ready`=1 and `start_addr`=(trig_addr - PRETRIG) mod 2^DEPTH_LOG2.
  - DONE -> PREFILL on `frame_ack` (normal/auto). DONE -> IDLE on `frame_ack` (single). `frame_ready` clears in the same transition.
- Normal mode with no crossing stays in ARMED indefinitely; to_cnt has no effect.
- `run`=0 in any state: IDLE next cycle, no further writes, `frame_ready` cleared. This has priority over all other transitions.
- Ignored inputs:
  - `frame_ack` outside DONE.
  - `arm` outside IDLE.
  - `sample_valid` in IDLE and DONE (the buffer is frozen while the frame is displayed).
- `mode`, `slope` and `TRIG` are sampled live every cycle, with no shadowing.

## Timing
- All outputs are registered.
- `wr_en` is high exactly one cycle, the cycle after the `sample_valid` cycle, with `wr_addr`/`wr_data` valid in that cycle.
- A state change takes effect the cycle after the qualifying `sample_valid`, `arm` or `frame_ack`.
- `frame_ready` and `state_o`=DONE rise in the same cycle as the last `wr_en`. `start_addr` and `trig_addr` are stable from that cycle until `frame_ack`.
- `reset` has priority over `run`. Reset mid-capture returns all outputs to reset values on the next edge.

## Test plan
Bench parameters: DEPTH_LOG2=6, PRETRIG=16, AUTO_TO=100, sample_valid every 4th cycle.
- Reset: assert `reset` 2 cycles -> all outputs 0, `state_o`=0; `sample_valid` pulses in IDLE produce no `wr_en`.
- Normal, rising, TRIG=2048, run=1, ramp 0,64,128,... from the first valid -> 16 PREFILL writes at addr 0-15. ARMED writes 1024..1984 at addr 16-31. Sample 2048 at addr 32 triggers: `trig_addr`=32. 48 post writes end at addr 15 (wrap). `frame_ready`=1 with `start_addr`=16. 80 `wr_en` total.
- Auto, constant 1000, TRIG=2048 -> forced trigger on the 100th ARMED sample, `auto_trig`=1, `frame_ready` after 48 more writes. Same stimulus in normal mode -> stays in ARMED after 500 samples, `frame_ready`=0.
- Falling slope, TRIG=2000, samples 2100,2050,2000 -> trigger on 2000. The sequence 2000,1990 does not trigger (prev not > TRIG).
- Single mode: `arm` pulse -> one frame. After `frame_ack` -> IDLE, no writes for 200 samples. A second `arm` -> new capture starting at the continued `wp`.
- Drop `run` mid-POST -> IDLE next cycle, `wr_en` stays 0, `frame_ready` never rises. Repeat with `reset` mid-POST -> all outputs 0.

Source files
------------

// File: rtl/acq_sequencer.sv
// -----------------------------------------------------------------------------
// acq_sequencer
// Acquisition sequencer for the scope sample path. It steers ADC samples into
// a circular waveform buffer. The sequence is pre-trigger fill, trigger wait,
// post-trigger capture and frame hand-off. The display therefore reads a
// stable frame that starts PRETRIG samples before the trigger crossing.
//
// Ports
//   CLK           in   system clock
//   reset         in   synchronous, active-high reset
//   run           in   level; 0 forces IDLE (highest priority after reset)
//   mode[1:0]     in   00 normal, 01 auto, 10 single, 11 normal
//   arm           in   one-cycle pulse; starts a capture in single mode
//   slope         in   0 rising, 1 falling trigger edge
//   TRIG[11:0]    in   trigger level (unsigned ADC code)
//   sample_valid  in   one-cycle strobe per ADC conversion
//   sample[11:0]  in   ADC code, valid with sample_valid
//   frame_ack     in   display reader has consumed the frame
//   wr_en         out  buffer write strobe
//   wr_addr       out  buffer write address
//   wr_data       out  buffer write data
//   frame_ready   out  a complete frame is held in the buffer
//   start_addr    out  address of the oldest sample of the frame
//   trig_addr     out  address of the trigger sample
//   auto_trig     out  current/last frame was force-triggered
//   state_o[2:0]  out  IDLE=0, PREFILL=1, ARMED=2, POST=3, DONE=4
// -----------------------------------------------------------------------------
module acq_sequencer #(
  parameter int DEPTH_LOG2 = 10,
  parameter int PRETRIG    = 128,
  parameter int AUTO_TO    = 4096
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  run,
  input  logic [1:0]            mode,
  input  logic                  arm,
  input  logic                  slope,
  input  logic [11:0]           TRIG,
  input  logic                  sample_valid,
  input  logic [11:0]           sample,
  input  logic                  frame_ack,
  output logic                  wr_en,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [11:0]           wr_data,
  output logic                  frame_ready,
  output logic [DEPTH_LOG2-1:0] start_addr,
  output logic [DEPTH_LOG2-1:0] trig_addr,
  output logic                  auto_trig,
  output logic [2:0]            state_o
);

  // One extra bit so the counters can hold 2^DEPTH_LOG2 without wrapping.
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int TO_W  = $clog2(AUTO_TO + 1);

  localparam logic [CNT_W-1:0]      PRE_LEN  = CNT_W'(PRETRIG);
  localparam logic [CNT_W-1:0]      POST_LEN = CNT_W'((1 << DEPTH_LOG2) - PRETRIG);
  localparam logic [TO_W:0]         TO_LEN   = (TO_W + 1)'(AUTO_TO);
  localparam logic [DEPTH_LOG2-1:0] PRE_OFS  = DEPTH_LOG2'(PRETRIG);
  // With PRETRIG = depth-1 the trigger sample alone completes the frame.
  localparam bit                    POST_ONE = (PRETRIG == ((1 << DEPTH_LOG2) - 1));

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DEPTH_LOG2-1:0] r_wp,         w_wp_nxt;
  logic [11:0]           r_prev,       w_prev_nxt;
  logic                  r_prev_valid, w_prev_valid_nxt;
  logic [CNT_W-1:0]      r_pre_cnt,    w_pre_cnt_nxt;
  logic [CNT_W-1:0]      r_post_cnt,   w_post_cnt_nxt;
  logic [TO_W-1:0]       r_to_cnt,     w_to_cnt_nxt;
  logic                  r_wr_en,      w_wr_en_nxt;
  logic [DEPTH_LOG2-1:0] r_wr_addr,    w_wr_addr_nxt;
  logic [11:0]           r_wr_data,    w_wr_data_nxt;
  logic                  r_frame_ready, w_frame_ready_nxt;
  logic [DEPTH_LOG2-1:0] r_start_addr, w_start_addr_nxt;
  logic [DEPTH_LOG2-1:0] r_trig_addr,  w_trig_addr_nxt;
  logic                  r_auto_trig,  w_auto_trig_nxt;

  logic                  w_active;
  logic                  w_write;
  logic                  w_cross;
  logic                  w_auto_fire;
  logic                  w_trig;
  logic                  w_enter_pre;
  logic                  w_enter_done;
  logic [CNT_W-1:0]      w_pre_inc;
  logic [CNT_W-1:0]      w_post_inc;
  logic [TO_W:0]         w_to_inc;

  assign w_active   = (r_state == S_PREFILL) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_write    = run && sample_valid && w_active;
  assign w_pre_inc  = r_pre_cnt + CNT_W'(1);
  assign w_post_inc = r_post_cnt + CNT_W'(1);
  assign w_to_inc   = {1'b0, r_to_cnt} + (TO_W + 1)'(1);

  // Trigger crossing detection; needs a previous sample from this capture.
  always_comb begin
    w_cross = 1'b0;
    if ((r_state == S_ARMED) && sample_valid && r_prev_valid) begin
      if (slope == 1'b0) begin
        w_cross = (r_prev < TRIG) && (sample >= TRIG);
      end else begin
        w_cross = (r_prev > TRIG) && (sample <= TRIG);
      end
    end else begin
      w_cross = 1'b0;
    end
  end

  // A real crossing wins over the timeout, so auto_trig marks only forced frames.
  assign w_auto_fire = (mode == 2'b01) && (r_state == S_ARMED) && sample_valid &&
                       (w_to_inc >= TO_LEN) && !w_cross;
  assign w_trig      = w_cross || w_auto_fire;

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; run=0 overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (!run) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((mode != 2'b10) || arm) w_state_nxt = S_PREFILL;
          else                        w_state_nxt = S_IDLE;
        end
        S_PREFILL: begin
          if (sample_valid && (w_pre_inc == PRE_LEN)) w_state_nxt = S_ARMED;
          else                                        w_state_nxt = S_PREFILL;
        end
        S_ARMED: begin
          if (w_trig) w_state_nxt = POST_ONE ? S_DONE : S_POST;
          else        w_state_nxt = S_ARMED;
        end
        S_POST: begin
          if (sample_valid && (w_post_inc == POST_LEN)) w_state_nxt = S_DONE;
          else                                          w_state_nxt = S_POST;
        end
        S_DONE: begin
          if (frame_ack) w_state_nxt = (mode == 2'b10) ? S_IDLE : S_PREFILL;
          else           w_state_nxt = S_DONE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_enter_pre  = (w_state_nxt == S_PREFILL) && (r_state != S_PREFILL);
  assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  // Next values for the datapath and the registered outputs.
  always_comb begin
    w_wr_en_nxt       = w_write;
    w_wr_addr_nxt     = r_wr_addr;
    w_wr_data_nxt     = r_wr_data;
    w_wp_nxt          = r_wp;
    w_prev_nxt        = r_prev;
    w_prev_valid_nxt  = r_prev_valid;
    w_pre_cnt_nxt     = r_pre_cnt;
    w_post_cnt_nxt    = r_post_cnt;
    w_to_cnt_nxt      = r_to_cnt;
    w_trig_addr_nxt   = r_trig_addr;
    w_auto_trig_nxt   = r_auto_trig;
    w_start_addr_nxt  = r_start_addr;
    // DONE is entered only on the last write and left only on ack or run=0.
    w_frame_ready_nxt = (w_state_nxt == S_DONE);

    if (w_write) begin
      w_wr_addr_nxt = r_wp;
      w_wr_data_nxt = sample;
      w_wp_nxt      = r_wp + DEPTH_LOG2'(1);
    end else begin
      w_wp_nxt      = r_wp;
    end

    // prev tracks every strobe regardless of state.
    if (sample_valid) begin
      w_prev_nxt = sample;
    end else begin
      w_prev_nxt = r_prev;
    end

    if (w_enter_pre) begin
      w_prev_valid_nxt = 1'b0;
      w_pre_cnt_nxt    = '0;
      w_post_cnt_nxt   = '0;
      w_to_cnt_nxt     = '0;
      w_auto_trig_nxt  = 1'b0;
    end else begin
      if (sample_valid) w_prev_valid_nxt = 1'b1;
      else              w_prev_valid_nxt = r_prev_valid;

      if (w_write) begin
        case (r_state)
          S_PREFILL: w_pre_cnt_nxt = w_pre_inc;
          S_ARMED: begin
            // Saturate so a long normal-mode wait cannot wrap the timeout.
            if (w_to_inc <= TO_LEN) w_to_cnt_nxt = w_to_inc[TO_W-1:0];
            else                    w_to_cnt_nxt = r_to_cnt;
            if (w_trig) begin
              w_post_cnt_nxt  = CNT_W'(1);
              w_trig_addr_nxt = r_wp;
              w_auto_trig_nxt = w_auto_fire;
            end else begin
              w_post_cnt_nxt  = r_post_cnt;
            end
          end
          S_POST:  w_post_cnt_nxt = w_post_inc;
          default: w_pre_cnt_nxt  = r_pre_cnt;
        endcase
      end else begin
        w_pre_cnt_nxt = r_pre_cnt;
      end
    end

    if (w_enter_done) begin
      w_start_addr_nxt = (w_trig ? r_wp : r_trig_addr) - PRE_OFS;
    end else begin
      w_start_addr_nxt = r_start_addr;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wp          <= '0;
      r_prev        <= 12'd0;
      r_prev_valid  <= 1'b0;
      r_pre_cnt     <= '0;
      r_post_cnt    <= '0;
      r_to_cnt      <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= 12'd0;
      r_frame_ready <= 1'b0;
      r_start_addr  <= '0;
      r_trig_addr   <= '0;
      r_auto_trig   <= 1'b0;
    end else begin
      r_wp          <= w_wp_nxt;
      r_prev        <= w_prev_nxt;
      r_prev_valid  <= w_prev_valid_nxt;
      r_pre_cnt     <= w_pre_cnt_nxt;
      r_post_cnt    <= w_post_cnt_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_wr_en       <= w_wr_en_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_wr_data     <= w_wr_data_nxt;
      r_frame_ready <= w_frame_ready_nxt;
      r_start_addr  <= w_start_addr_nxt;
      r_trig_addr   <= w_trig_addr_nxt;
      r_auto_trig   <= w_auto_trig_nxt;
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_ready = r_frame_ready;
  assign start_addr  = r_start_addr;
  assign trig_addr   = r_trig_addr;
  assign auto_trig   = r_auto_trig;
  assign state_o     = r_state;

endmodule

// File: tb/tb_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acq_sequencer
// Directed bench for acq_sequencer with DEPTH_LOG2=6, PRETRIG=16, AUTO_TO=100.
// A sample strobe is issued every 4th cycle. Inputs are driven on the falling
// edge. Outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_acq_sequencer;

  localparam int DL = 6;
  localparam int PT = 16;
  localparam int AT = 100;

  logic          CLK;
  logic          reset;
  logic          run;
  logic [1:0]    mode;
  logic          arm;
  logic          slope;
  logic [11:0]   TRIG;
  logic          sample_valid;
  logic [11:0]   sample;
  logic          frame_ack;
  logic          wr_en;
  logic [DL-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          frame_ready;
  logic [DL-1:0] start_addr;
  logic [DL-1:0] trig_addr;
  logic          auto_trig;
  logic [2:0]    state_o;

  int            n_checks = 0;
  int            n_errors = 0;
  int            wr_count = 0;
  int            fr_at_wr = 0;
  logic [DL-1:0] last_addr = '0;
  logic [11:0]   last_data = 12'd0;

  acq_sequencer #(.DEPTH_LOG2(DL), .PRETRIG(PT), .AUTO_TO(AT)) dut (
    .CLK(CLK), .reset(reset), .run(run), .mode(mode), .arm(arm), .slope(slope),
    .TRIG(TRIG), .sample_valid(sample_valid), .sample(sample), .frame_ack(frame_ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_ready(frame_ready),
    .start_addr(start_addr), .trig_addr(trig_addr), .auto_trig(auto_trig),
    .state_o(state_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Write monitor: counts buffer writes and remembers the latest one.
  always @(negedge CLK) begin
    if (wr_en === 1'b1) begin
      wr_count  = wr_count + 1;
      last_addr = wr_addr;
      last_data = wr_data;
      if (frame_ready === 1'b1) fr_at_wr = fr_at_wr + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One sample strobe followed by three idle cycles.
  task automatic send(input logic [11:0] v);
    sample_valid = 1'b1;
    sample       = v;
    @(negedge CLK);
    sample_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic send_n(input int n, input logic [11:0] v);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge CLK);
    arm = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    @(negedge CLK);
    frame_ack = 1'b0;
    @(negedge CLK);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_wr_en"},   32'(wr_en),       32'd0);
    check_val({tag, "_wr_addr"}, 32'(wr_addr),     32'd0);
    check_val({tag, "_wr_data"}, 32'(wr_data),     32'd0);
    check_val({tag, "_frame"},   32'(frame_ready), 32'd0);
    check_val({tag, "_start"},   32'(start_addr),  32'd0);
    check_val({tag, "_trig"},    32'(trig_addr),   32'd0);
    check_val({tag, "_auto"},    32'(auto_trig),   32'd0);
    check_val({tag, "_state"},   32'(state_o),     32'd0);
  endtask

  initial begin
    logic [11:0] v;
    reset = 1'b1; run = 1'b0; mode = 2'b00; arm = 1'b0; slope = 1'b0;
    TRIG = 12'd0; sample_valid = 1'b0; sample = 12'd0; frame_ack = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_zero("reset");
    reset = 1'b0;

    // Single mode without arm stays IDLE; strobes are ignored.
    mode = 2'b10; run = 1'b1;
    @(negedge CLK);
    send_n(3, 12'd500);
    check_val("idle_state", 32'(state_o), 32'd0);
    check_val("idle_writes", 32'(wr_count), 32'd0);

    // Normal mode, rising edge at 2048, ramp 0,64,128,...
    mode = 2'b00; TRIG = 12'd2048; slope = 1'b0;
    @(negedge CLK);
    check_val("n_prefill", 32'(state_o), 32'd1);
    for (int k = 0; k < 16; k++) begin
      v = 12'((k * 64) % 4096);
      send(v);
    end
    check_val("n_armed", 32'(state_o), 32'd2);
    check_val("n_pre_addr", 32'(last_addr), 32'd15);
    for (int k = 16; k < 32; k++) begin
      v = 12'((k * 64) % 4096);
      send(v);
    end
    check_val("n_armed2", 32'(state_o), 32'd2);
    check_val("n_arm_addr", 32'(last_addr), 32'd31);
    check_val("n_arm_data", 32'(last_data), 32'd1984);
    pulse_ack();
    check_val("n_ack_ignored", 32'(state_o), 32'd2);
    send(12'd2048);
    check_val("n_post", 32'(state_o), 32'd3);
    check_val("n_trig_addr", 32'(trig_addr), 32'd32);
    check_val("n_trig_wr", 32'(last_addr), 32'd32);
    for (int k = 33; k < 79; k++) begin
      v = 12'((k * 64) % 4096);
      send(v);
    end
    check_val("n_post_still", 32'(state_o), 32'd3);
    check_val("n_not_ready", 32'(frame_ready), 32'd0);
    send(12'd960);
    check_val("n_done", 32'(state_o), 32'd4);
    check_val("n_ready", 32'(frame_ready), 32'd1);
    check_val("n_start", 32'(start_addr), 32'd16);
    check_val("n_last_addr", 32'(last_addr), 32'd15);
    check_val("n_wr_total", 32'(wr_count), 32'd80);
    send_n(3, 12'd100);
    check_val("n_frozen", 32'(wr_count), 32'd80);
    check_val("n_hold_trig", 32'(trig_addr), 32'd32);
    pulse_ack();
    check_val("n_ack_prefill", 32'(state_o), 32'd1);
    check_val("n_ack_clear", 32'(frame_ready), 32'd0);

    // Auto mode, constant 1000: forced trigger on the 100th ARMED sample.
    mode = 2'b01;
    send_n(16, 12'd1000);
    check_val("a_armed", 32'(state_o), 32'd2);
    send_n(99, 12'd1000);
    check_val("a_wait", 32'(state_o), 32'd2);
    check_val("a_no_auto", 32'(auto_trig), 32'd0);
    send(12'd1000);
    check_val("a_post", 32'(state_o), 32'd3);
    check_val("a_auto", 32'(auto_trig), 32'd1);
    check_val("a_trig_addr", 32'(trig_addr), 32'd3);
    send_n(46, 12'd1000);
    check_val("a_post_still", 32'(state_o), 32'd3);
    send(12'd1000);
    check_val("a_done", 32'(state_o), 32'd4);
    check_val("a_ready", 32'(frame_ready), 32'd1);
    check_val("a_start", 32'(start_addr), 32'd51);
    check_val("a_wr_total", 32'(wr_count), 32'd243);
    pulse_ack();
    check_val("a_restart", 32'(state_o), 32'd1);
    check_val("a_auto_clr", 32'(auto_trig), 32'd0);

    // Same stimulus in normal mode never triggers.
    mode = 2'b00;
    send_n(516, 12'd1000);
    check_val("nn_armed", 32'(state_o), 32'd2);
    check_val("nn_not_ready", 32'(frame_ready), 32'd0);
    check_val("nn_wr_total", 32'(wr_count), 32'd759);

    // Falling edge at 2000.
    slope = 1'b1; TRIG = 12'd2000;
    send(12'd2000);
    send(12'd1990);
    check_val("f_no_trig", 32'(state_o), 32'd2);
    send(12'd2100);
    send(12'd2050);
    check_val("f_above", 32'(state_o), 32'd2);
    send(12'd2000);
    check_val("f_post", 32'(state_o), 32'd3);
    check_val("f_trig_addr", 32'(trig_addr), 32'd59);
    send_n(5, 12'd1500);
    check_val("f_wr_total", 32'(wr_count), 32'd769);

    // run dropped mid-POST, together with a strobe.
    run = 1'b0; sample_valid = 1'b1; sample = 12'd777;
    @(negedge CLK);
    sample_valid = 1'b0;
    check_val("r_idle", 32'(state_o), 32'd0);
    check_val("r_no_wr", 32'(wr_en), 32'd0);
    send_n(3, 12'd777);
    check_val("r_wr_total", 32'(wr_count), 32'd769);
    check_val("r_not_ready", 32'(frame_ready), 32'd0);

    // Single mode: waits for arm, one frame, then back to IDLE.
    mode = 2'b10; slope = 1'b0; TRIG = 12'd2048; run = 1'b1;
    @(negedge CLK);
    send_n(2, 12'd0);
    check_val("s_wait_arm", 32'(state_o), 32'd0);
    check_val("s_no_wr", 32'(wr_count), 32'd769);
    pulse_arm();
    check_val("s_prefill", 32'(state_o), 32'd1);
    send(12'd0);
    check_val("s_first_addr", 32'(last_addr), 32'd1);
    send_n(15, 12'd0);
    check_val("s_armed", 32'(state_o), 32'd2);
    send(12'd0);
    send(12'd2048);
    check_val("s_post", 32'(state_o), 32'd3);
    check_val("s_trig_addr", 32'(trig_addr), 32'd18);
    send_n(46, 12'd0);
    check_val("s_post_still", 32'(state_o), 32'd3);
    send(12'd0);
    check_val("s_done", 32'(state_o), 32'd4);
    check_val("s_ready", 32'(frame_ready), 32'd1);
    check_val("s_start", 32'(start_addr), 32'd2);
    check_val("s_last_addr", 32'(last_addr), 32'd1);
    check_val("s_wr_total", 32'(wr_count), 32'd834);
    pulse_ack();
    check_val("s_idle", 32'(state_o), 32'd0);
    check_val("s_ack_clear", 32'(frame_ready), 32'd0);
    send_n(200, 12'd3000);
    check_val("s_idle_hold", 32'(state_o), 32'd0);
    check_val("s_idle_wr", 32'(wr_count), 32'd834);
    pulse_arm();
    check_val("s2_prefill", 32'(state_o), 32'd1);
    send(12'd0);
    check_val("s2_first_addr", 32'(last_addr), 32'd2);
    send_n(15, 12'd0);
    send(12'd0);
    send(12'd2048);
    check_val("s2_post", 32'(state_o), 32'd3);
    check_val("s2_trig_addr", 32'(trig_addr), 32'd19);
    send_n(3, 12'd0);
    check_val("s2_wr_total", 32'(wr_count), 32'd855);

    // Reset mid-POST.
    reset = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check_zero("rst_post");
    reset = 1'b0;
    @(negedge CLK);
    check_val("rst_idle", 32'(state_o), 32'd0);
    check_val("frames_at_last_wr", 32'(fr_at_wr), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
